integration_gpio_pio: RTL and testbench

INTEGRATION_GPIO_PIO -- requirements
Module: integration_gpio_pio

---
 rtl/integration_pio_pkg.sv | 19 +
 rtl/integration_pio_sync.sv | 23 ++
 rtl/integration_gpio_pio.sv | 104 ++++++++++
 tb/tb_integration_gpio_pio.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/integration_pio_pkg.sv
// Shared register map and edge-select encodings for the PIO block.
package integration_pio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic pio_write(input logic cs, input logic wr_n);
        return cs & ~wr_n;
    endfunction

endpackage

// File: rtl/integration_pio_sync.sv
// Two-flop synchronizer for the asynchronous pad inputs.
module integration_pio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/integration_gpio_pio.sv
// Memory-mapped GPIO: data/direction registers, set/clear aliases, sticky
// edge capture with W1C and a registered, masked interrupt.
module integration_gpio_pio
    import integration_pio_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter logic [31:0] RESET_VALUE = 32'h3136,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter logic [31:0] DIR_RESET   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] ec_clr;
    logic [WIDTH-1:0] rd_w;

    assign wr        = pio_write(chipselect, write_n);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    integration_pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_in)
    );

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_hit = ~sync_in & sync_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_hit = sync_in ^ sync_d;
        end else begin : g_rise
            assign edge_hit = sync_in & ~sync_d;
        end
    endgenerate

    assign ec_clr = (wr && address == ADDR_EDGECAPTURE) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE[WIDTH-1:0];
            direction   <= DIR_RESET[WIDTH-1:0];
            irqmask     <= '0;
            edgecapture <= '0;
            sync_d      <= '0;
            irq         <= 1'b0;
        end else begin
            sync_d <= sync_in;
            // A new edge wins over a same-cycle W1C on the same bit.
            edgecapture <= (edgecapture & ~ec_clr) | edge_hit;
            irq         <= |(edgecapture & irqmask);
            if (wr) begin
                case (address)
                    ADDR_DATA:      data_out  <= wd;
                    ADDR_DIRECTION: direction <= wd;
                    ADDR_IRQMASK:   irqmask   <= wd;
                    ADDR_OUTSET:    data_out  <= data_out | wd;
                    ADDR_OUTCLEAR:  data_out  <= data_out & ~wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_w = '0;
        case (address)
            ADDR_DATA:        rd_w = (data_out & direction) | (sync_in & ~direction);
            ADDR_DIRECTION:   rd_w = direction;
            ADDR_IRQMASK:     rd_w = irqmask;
            ADDR_EDGECAPTURE: rd_w = edgecapture;
            ADDR_OUTSET,
            ADDR_OUTCLEAR:    rd_w = data_out;
            default:          rd_w = '0;
        endcase
        readdata            = '0;
        readdata[WIDTH-1:0] = rd_w;
    end

    assign out_port = data_out;
    assign oe_port  = direction;

endmodule

// File: tb/tb_integration_gpio_pio.sv
// Directed bench for integration_gpio_pio with an expected-value queue.
module tb_integration_gpio_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] in_port;
    logic [15:0] out_port;
    logic [15:0] oe_port;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rv;

    integration_gpio_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;

        // Reset state
        exp_q.push_back(32'h3136); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);    exp_q.push_back(32'h0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("rst_out", 32'(out_port));
        chk("rst_oe", 32'(oe_port));
        chk("rst_irq", 32'(irq));
        rd(3'd2, rv); chk("rst_irqmask_rd", rv);
        rd(3'd3, rv); chk("rst_ec_rd", rv);

        // Data write, set and clear aliases
        wr(3'd1, 32'h0000_FFFF);
        wr(3'd0, 32'h0000_00F0);
        wr(3'd4, 32'h0000_000F);
        wr(3'd5, 32'h0000_00C0);
        exp_q.push_back(32'h003F); exp_q.push_back(32'h003F);
        exp_q.push_back(32'h003F); exp_q.push_back(32'h003F); exp_q.push_back(32'hFFFF);
        chk("setclr_out", 32'(out_port));
        rd(3'd0, rv); chk("setclr_data_rd", rv);
        rd(3'd4, rv); chk("outset_rd", rv);
        rd(3'd5, rv); chk("outclear_rd", rv);
        chk("dir_oe", 32'(oe_port));

        // Unmapped address: write ignored, reads zero
        wr(3'd6, 32'hFFFF_FFFF);
        exp_q.push_back(32'h003F); exp_q.push_back(32'h0);
        chk("addr6_ignored", 32'(out_port));
        rd(3'd6, rv); chk("addr6_rd", rv);

        // Mixed direction read; upper writedata bits ignored
        wr(3'd1, 32'h0000_00FF);
        wr(3'd0, 32'hFFFF_1234);
        in_port = 16'hAB00;
        exp_q.push_back(32'h0000_AB34); exp_q.push_back(32'h0000_AB00);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        step(); step(); step();
        rd(3'd0, rv); chk("mixed_data_rd", rv);
        rd(3'd3, rv); chk("mixed_ec", rv);
        chk("mixed_irq_masked", 32'(irq));
        wr(3'd3, 32'h0000_FFFF);
        rd(3'd3, rv); chk("w1c_all", rv);

        // Rising edge on bit 0 -> edgecapture at +3, irq at +4
        wr(3'd2, 32'h0000_0001);
        in_port = 16'hAB01;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        step(); rd(3'd3, rv); chk("edge_n1", rv);
        step(); rd(3'd3, rv); chk("edge_n2", rv);
        step(); rd(3'd3, rv); chk("edge_n3", rv);
        chk("irq_n3", 32'(irq));
        step(); chk("irq_n4", 32'(irq));
        wr(3'd3, 32'h0000_0001);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        rd(3'd3, rv); chk("w1c_bit0", rv);
        chk("irq_lag", 32'(irq));
        step(); chk("irq_cleared", 32'(irq));

        // Falling edge not captured in rising mode
        in_port = 16'hAB00;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        step(); step(); step(); step();
        rd(3'd3, rv); chk("fall_ignored", rv);
        chk("fall_irq", 32'(irq));

        // Edge and W1C colliding on bit 2: set wins
        in_port = 16'hAB04;
        exp_q.push_back(32'h4);
        step(); step();
        wr(3'd3, 32'h0000_0004);
        rd(3'd3, rv); chk("collision", rv);
        wr(3'd2, 32'h0000_0004);
        exp_q.push_back(32'h1);
        step(); chk("irq_bit2", 32'(irq));

        // Reset mid-operation with a DATA write on the bus
        address = 3'd0; writedata = 32'h0000_FFFF; chipselect = 1'b1; write_n = 1'b0;
        #1;
        reset_n = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h3136); exp_q.push_back(32'h0);
        #1;
        chk("midrst_irq", 32'(irq));
        chk("midrst_out", 32'(out_port));
        chk("midrst_oe", 32'(oe_port));
        step();
        chipselect = 1'b0; write_n = 1'b1;
        step();
        reset_n = 1'b1;
        exp_q.push_back(32'h3136); exp_q.push_back(32'h0);
        chk("midrst_write_dropped", 32'(out_port));
        rd(3'd2, rv); chk("midrst_irqmask", rv);

        // Input high at reset release -> one rising edge 3 cycles later
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'hAB04);
        step(); rd(3'd3, rv); chk("rel_n1", rv);
        step(); rd(3'd3, rv); chk("rel_n2", rv);
        step(); rd(3'd3, rv); chk("rel_n3", rv);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
